// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_arbiter
// Purpose  : Two-port round-robin arbiter with a bounded port 1 lock. A
//            registered access stage drives the data memory.
// Options  : DM_ARB_RANGE_CHECK_EN adds r0_err/r1_err. With it, writes to
//            addresses above the decoded range are suppressed.
// Revision : 1.0 - initial release
// ============================================================================
module dm_arbiter #(
  parameter int MEM_AW   = 12,
  parameter int MAX_LOCK = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        r0_valid,
  input  logic        r0_write,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_ready,
  output logic        r0_rsp_valid,
  output logic [31:0] r0_rdata,
  input  logic        r1_valid,
  input  logic        r1_write,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_ready,
  output logic        r1_rsp_valid,
  output logic [31:0] r1_rdata,
  input  logic        r1_lock,
  output logic [31:0] dm_address,
  output logic [31:0] dm_data_in,
  output logic        dm_mem_write,
  input  logic [31:0] dm_data_out,
  output logic        busy
`ifdef DM_ARB_RANGE_CHECK_EN
  ,
  output logic        r0_err,
  output logic        r1_err
`endif
);

  localparam int              c_cw       = $clog2(MAX_LOCK + 1);
  localparam logic [c_cw-1:0] c_lock_max = c_cw'(MAX_LOCK);
  localparam logic [c_cw-1:0] c_lock_one = c_cw'(1);
`ifdef DM_ARB_RANGE_CHECK_EN
  localparam logic            c_range_check = 1'b1;
`else
  localparam logic            c_range_check = 1'b0;
`endif

  // Arbiter state
  logic            r_last_grant;
  logic [c_cw-1:0] r_lock_cnt;

  // Access stage
  logic        r_stg_valid;
  logic        r_stg_port;
  logic        r_stg_write;
  logic        r_stg_err;
  logic [31:0] r_stg_addr;
  logic [31:0] r_stg_wdata;

  // Response stage
  logic        r_rsp_valid0;
  logic        r_rsp_valid1;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  logic        w_lock_active;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_grant_any;
  logic        w_sel_write;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_req_err;
  logic [c_cw-1:0] w_lock_cnt_nxt;

  assign w_lock_active = r_last_grant & r1_lock & r1_valid & (r_lock_cnt < c_lock_max);

  // When both ports want the memory, port 1 wins only if port 0 was last or the lock holds.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r0_valid && !r1_valid) begin
      w_grant0 = 1'b1;
    end else if (!r0_valid && r1_valid) begin
      w_grant1 = 1'b1;
    end else if (r0_valid && r1_valid) begin
      if (w_lock_active || !r_last_grant) begin
        w_grant1 = 1'b1;
      end else begin
        w_grant0 = 1'b1;
      end
    end
  end

  assign w_grant_any = w_grant0 | w_grant1;
  assign r0_ready    = w_grant0;
  assign r1_ready    = w_grant1;

  // Count only the port 1 grants taken while port 0 is left waiting.
  always_comb begin
    w_lock_cnt_nxt = r_lock_cnt;
    if (!r1_lock || w_grant0 || !w_grant_any) begin
      w_lock_cnt_nxt = '0;
    end else if (w_grant1 && r0_valid) begin
      w_lock_cnt_nxt = r_lock_cnt + c_lock_one;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_lock_cnt   <= '0;
    end else begin
      r_lock_cnt <= w_lock_cnt_nxt;
      if (w_grant_any) begin
        r_last_grant <= w_grant1;
      end
    end
  end

  assign w_sel_write = w_grant1 ? r1_write : r0_write;
  assign w_sel_addr  = w_grant1 ? r1_addr  : r0_addr;
  assign w_sel_wdata = w_grant1 ? r1_wdata : r0_wdata;
  assign w_req_err   = c_range_check & (|w_sel_addr[31:MEM_AW]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stg_valid <= 1'b0;
      r_stg_port  <= 1'b0;
      r_stg_write <= 1'b0;
      r_stg_err   <= 1'b0;
      r_stg_addr  <= '0;
      r_stg_wdata <= '0;
    end else begin
      r_stg_valid <= w_grant_any;
      if (w_grant_any) begin
        r_stg_port  <= w_grant1;
        r_stg_write <= w_sel_write;
        r_stg_err   <= w_req_err;
        r_stg_addr  <= w_sel_addr;
        r_stg_wdata <= w_sel_wdata;
      end
    end
  end

  assign dm_address   = r_stg_addr;
  assign dm_data_in   = r_stg_wdata;
  assign dm_mem_write = r_stg_valid & r_stg_write & ~r_stg_err;
  assign busy         = r_stg_valid;

  // Write acknowledges leave rdata untouched; errored accesses return zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid0 <= 1'b0;
      r_rsp_valid1 <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_rsp_valid0 <= r_stg_valid & ~r_stg_port;
      r_rsp_valid1 <= r_stg_valid &  r_stg_port;
      if (r_stg_valid && !r_stg_port) begin
        if (r_stg_err) begin
          r_rdata0 <= '0;
        end else if (!r_stg_write) begin
          r_rdata0 <= dm_data_out;
        end
      end
      if (r_stg_valid && r_stg_port) begin
        if (r_stg_err) begin
          r_rdata1 <= '0;
        end else if (!r_stg_write) begin
          r_rdata1 <= dm_data_out;
        end
      end
    end
  end

  assign r0_rsp_valid = r_rsp_valid0;
  assign r1_rsp_valid = r_rsp_valid1;
  assign r0_rdata     = r_rdata0;
  assign r1_rdata     = r_rdata1;

`ifdef DM_ARB_RANGE_CHECK_EN
  logic r_err0;
  logic r_err1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
    end else begin
      r_err0 <= r_stg_valid & ~r_stg_port & r_stg_err;
      r_err1 <= r_stg_valid &  r_stg_port & r_stg_err;
    end
  end

  assign r0_err = r_err0;
  assign r1_err = r_err1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_arbiter
// Purpose  : Scoreboard bench for dm_arbiter with a behavioural data memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        r0_valid, r0_write, r0_ready, r0_rsp_valid;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic        r1_valid, r1_write, r1_ready, r1_rsp_valid, r1_lock;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic [31:0] dm_address, dm_data_in, dm_data_out;
  logic        dm_mem_write, busy;
`ifdef DM_ARB_RANGE_CHECK_EN
  logic        r0_err, r1_err;
  localparam logic c_rc = 1'b1;
`else
  localparam logic c_rc = 1'b0;
`endif

  always #5 clock = ~clock;

  dm_arbiter #(.MEM_AW(12), .MAX_LOCK(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .r0_valid(r0_valid), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_rsp_valid(r0_rsp_valid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_rsp_valid(r1_rsp_valid), .r1_rdata(r1_rdata),
    .r1_lock(r1_lock),
    .dm_address(dm_address), .dm_data_in(dm_data_in), .dm_mem_write(dm_mem_write),
    .dm_data_out(dm_data_out), .busy(busy)
`ifdef DM_ARB_RANGE_CHECK_EN
    , .r0_err(r0_err), .r1_err(r1_err)
`endif
  );

  // 4 KB memory: async read, write on the clock edge
  logic [31:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  always @(posedge clock) if (dm_mem_write) mem[dm_address[11:2]] <= dm_data_in;
  assign dm_data_out = mem[dm_address[11:2]];

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;
  always @(posedge clock) cycle++;

  typedef struct {
    logic        port;
    logic        wr;
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;
  exp_t        sbq[$];
  logic [31:0] last_rd [2];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cycle);
    end
  endtask

  // Monitor: pops one expectation per response strobe
  always @(negedge clock) begin
    if (reset_n) begin
      n_tests++;
      if (r0_ready && r1_ready) begin
        n_fail++;
        $display("FAIL two_ready: both ready asserted (cycle %0d)", cycle);
      end
      if (r0_rsp_valid || r1_rsp_valid) begin
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rsp: r0_rsp=%b r1_rsp=%b with nothing pending (cycle %0d)",
                   r0_rsp_valid, r1_rsp_valid, cycle);
        end else begin
          exp_t        e;
          logic [31:0] exp_d;
          logic [31:0] got_d;
          e     = sbq.pop_front();
          exp_d = e.err ? 32'h0 : (e.wr ? last_rd[e.port] : e.data);
          got_d = e.port ? r1_rdata : r0_rdata;
          last_rd[e.port] = exp_d;
          if ((e.port ? r1_rsp_valid : r0_rsp_valid) !== 1'b1 || e.due != cycle) begin
            n_fail++;
            $display("FAIL rsp_timing: port %0d at cycle %0d, expected port %0d at cycle %0d",
                     r1_rsp_valid, cycle, e.port, e.due);
          end
          chk("rsp_rdata", got_d, exp_d);
`ifdef DM_ARB_RANGE_CHECK_EN
          chk("rsp_err", 32'(e.port ? r1_err : r0_err), 32'(e.err));
`endif
        end
      end else if (sbq.size() != 0 && sbq[0].due < cycle) begin
        exp_t e;
        e = sbq.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL missing_rsp: port %0d due cycle %0d, none by cycle %0d", e.port, e.due, cycle);
      end
    end
  end

  // One cycle of stimulus; eg = expected grant (0 none, 1 port 0, 2 port 1)
  task automatic cyc(input logic v0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic v1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                     input logic lk, input int eg, input logic [31:0] ed, input logic ee);
    int   got;
    exp_t e;
    @(posedge clock);
    #1;
    r0_valid = v0; r0_write = w0; r0_addr = a0; r0_wdata = d0;
    r1_valid = v1; r1_write = w1; r1_addr = a1; r1_wdata = d1;
    r1_lock  = lk;
    @(negedge clock);
    got = (r0_ready && r1_ready) ? 3 : r1_ready ? 2 : r0_ready ? 1 : 0;
    n_tests++;
    if (got != eg) begin
      n_fail++;
      $display("FAIL grant: got %0d expected %0d (cycle %0d)", got, eg, cycle);
    end
    if (eg != 0) begin
      e.port = (eg == 2);
      e.wr   = (eg == 2) ? w1 : w0;
      e.data = ed;
      e.err  = ee;
      e.due  = cycle + 2;
      sbq.push_back(e);
    end
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 32'h0, 1'b0);
  endtask

  task automatic p0(input logic w, input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] ed, input logic ee);
    cyc(1'b1, w, a, d, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1, ed, ee);
  endtask

  task automatic p1(input logic w, input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] ed, input logic ee);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, w, a, d, 1'b0, 2, ed, ee);
  endtask

  // Both ports read: port 0 reads a0 (value e0), port 1 reads a1 (value e1)
  task automatic both(input logic [31:0] a0, input logic [31:0] e0, input logic [31:0] a1,
                      input logic [31:0] e1, input logic lk, input int eg);
    cyc(1'b1, 1'b0, a0, 32'h0, 1'b1, 1'b0, a1, 32'h0, lk, eg, (eg == 2) ? e1 : e0, 1'b0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_rsp0", 32'(r0_rsp_valid), 32'h0);
    chk("rst_rsp1", 32'(r1_rsp_valid), 32'h0);
    chk("rst_rdata0", r0_rdata, 32'h0);
    chk("rst_rdata1", r1_rdata, 32'h0);
    chk("rst_dm_write", 32'(dm_mem_write), 32'h0);
    chk("rst_dm_addr", dm_address, 32'h0);
    chk("rst_dm_din", dm_data_in, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    reset_n  = 1'b0;
    r0_valid = 1'b0; r0_write = 1'b0; r0_addr = 32'h0; r0_wdata = 32'h0;
    r1_valid = 1'b0; r1_write = 1'b0; r1_addr = 32'h0; r1_wdata = 32'h0;
    r1_lock  = 1'b0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_outputs();
    chk("rst_ready0", 32'(r0_ready), 32'h0);
    reset_n = 1'b1;

    // Write then read back through port 0
    p0(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    chk("empty_no_write", 32'(dm_mem_write), 32'h0);
    p0(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    chk("stage_write", 32'(dm_mem_write), 32'h1);
    chk("stage_addr", dm_address, 32'h10);
    chk("stage_wdata", dm_data_in, 32'hDEADBEEF);
    chk("stage_busy", 32'(busy), 32'h1);
    idle();
    chk("read_no_write", 32'(dm_mem_write), 32'h0);

    // Round robin without lock; low address bits are ignored
    p1(1'b1, 32'h14, 32'hCAFE0001, 32'h0, 1'b0);
    both(32'h10, 32'hDEADBEEF, 32'h14, 32'hCAFE0001, 1'b0, 1);
    both(32'h13, 32'hDEADBEEF, 32'h14, 32'hCAFE0001, 1'b0, 2);
    both(32'h10, 32'hDEADBEEF, 32'h17, 32'hCAFE0001, 1'b0, 1);
    both(32'h10, 32'hDEADBEEF, 32'h14, 32'hCAFE0001, 1'b0, 2);

    // Read-after-write across ports in consecutive grants
    p1(1'b1, 32'h20, 32'h00000004, 32'h0, 1'b0);
    p0(1'b0, 32'h20, 32'h0, 32'h00000004, 1'b0);

    // Lock: 16 port 1 grants, one port 0 grant, then port 1 again
    for (int i = 0; i < 16; i++) both(32'h10, 32'hDEADBEEF, 32'h20, 32'h4, 1'b1, 2);
    both(32'h10, 32'hDEADBEEF, 32'h20, 32'h4, 1'b1, 1);
    both(32'h10, 32'hDEADBEEF, 32'h20, 32'h4, 1'b1, 2);
    both(32'h10, 32'hDEADBEEF, 32'h20, 32'h4, 1'b1, 2);
    both(32'h10, 32'hDEADBEEF, 32'h20, 32'h4, 1'b0, 1);
    idle();

    // Reset in the cycle after a write is accepted
    p0(1'b1, 32'h30, 32'h11111111, 32'h0, 1'b0);
    idle();
    idle();
    p0(1'b1, 32'h30, 32'h22222222, 32'h0, 1'b0);
    @(posedge clock);
    #1;
    reset_n  = 1'b0;
    r0_valid = 1'b0;
    sbq.delete();
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    @(negedge clock);
    check_reset_outputs();
    @(negedge clock);
    reset_n = 1'b1;
    idle();
    idle();
    chk("post_rst_rsp0", 32'(r0_rsp_valid), 32'h0);
    p0(1'b0, 32'h30, 32'h0, 32'h11111111, 1'b0);

    // Addresses above the decoded range: aliasing, or error when checked
    p0(1'b1, 32'h0, 32'hA5A5A5A5, 32'h0, 1'b0);
    p0(1'b1, 32'h1000, 32'h00005555, 32'h0, c_rc);
    p0(1'b0, 32'h0, 32'h0, c_rc ? 32'hA5A5A5A5 : 32'h00005555, 1'b0);
    p0(1'b0, 32'h1000, 32'h0, c_rc ? 32'h0 : 32'h00005555, c_rc);

    repeat (4) idle();
    chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-requester arbiter and sequencer for the 4 KB single-port data memory (async read, sync write on clock).
- Port 0 is the pipeline MEM stage. Port 1 is the loader/DMA path.
- Round-robin arbitration with a bounded lock for port 1 bursts.
- Registered access stage drives the memory; the registered read data is returned to the winning port.

Parameters:
- MEM_AW, 12, byte-address width decoded by the data memory; word index is addr[MEM_AW-1:2].
- MAX_LOCK, 16, maximum consecutive grants held by port 1 via r1_lock while port 0 waits.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- r0_valid  in  1  port 0 request
- r0_write  in  1  1 = write, 0 = read
- r0_addr  in  32  byte address
- r0_wdata  in  32  write data
- r0_ready  out  1  request accepted this cycle (valid & ready)
- r0_rsp_valid  out  1  one-cycle response strobe
- r0_rdata  out  32  read data, valid with r0_rsp_valid
- r1_valid, r1_write, r1_addr, r1_wdata, r1_ready, r1_rsp_valid, r1_rdata  same as port 0
- r1_lock  in  1  port 1 requests to keep the grant
- dm_address  out  32  to memory address
- dm_data_in  out  32  to memory data_in
- dm_mem_write  out  1  to memory write enable
- dm_data_out  in  32  from memory data_out
- busy  out  1  access stage occupied

Behaviour:
- Reset (async, reset_n=0): all state cleared. Outputs: r*_ready=0, r*_rsp_valid=0, r*_rdata=0, dm_mem_write=0, dm_address=0, dm_data_in=0, busy=0. last_grant=1, so port 0 wins first. Lock counter=0.
- r*_ready is combinational from valid inputs and arbiter state, never from rdata. At most one ready per cycle.
- Arbitration, cycle A:
  - Only one port valid: that port is granted.
  - Both valid, no lock active: the port != last_grant is granted.
  - Lock active (last_grant=1, r1_lock=1, r1_valid=1, lock_cnt<MAX_LOCK): port 1 is granted.
  - Lock counter increments on each port 1 grant while r0_valid=1 and lock active.
  - At lock_cnt==MAX_LOCK, port 0 is granted for one transaction; counter clears.
  - Counter also clears when r1_lock=0 or on any port 0 grant.
- Access stage (cycle A+1): the accepted request is held in registers.
  - dm_address = registered addr; dm_data_in = registered wdata.
  - dm_mem_write = registered write & stage-valid.
  - busy = stage-valid.
  - dm_mem_write is never asserted when the stage is empty.
- Response (cycle A+2): the granted port's rsp_valid=1 for exactly one cycle.
  - Reads: rdata = dm_data_out sampled at end of A+1.
  - Writes: rsp_valid still pulses as write acknowledge; rdata holds its previous value.
- Fully pipelined: a new grant is allowed every cycle, so throughput is 1 access/cycle. Latency is 2 cycles from acceptance to response.
- Read-after-write to the same word in consecutive grants returns the new data; the write commits at the end of A+1 and the next read samples in A+2.
- Address bits [1:0] are ignored (word aligned). Bits above MEM_AW-1 are passed through unchanged; the memory aliases them.
- Reset mid-operation:
  - The in-flight access is discarded; no write occurs after reset assertion.
  - No rsp_valid pulse is issued for it.
- Simultaneous valid deassertion with no grant: no state change except lock counter clear.

Optional Feature:
- Macro: DM_ARB_RANGE_CHECK_EN.
- Defined:
  - Adds outputs r0_err and r1_err (1 bit each), valid with rsp_valid.
  - A request with addr[31:MEM_AW] != 0 is accepted normally and reaches the access stage, but dm_mem_write is forced to 0.
  - Response has err=1 and rdata=0.
  - In-range responses have err=0.
- Undefined: no err ports; addresses alias as described.

Test Plan:
- Reset, then r0 write addr 0x10 data 0xDEADBEEF, then r0 read 0x10 → r0_ready at accept; dm_mem_write=1 one cycle later; r0_rsp_valid 2 cycles after the read accept with r0_rdata=0xDEADBEEF.
- r0 and r1 both valid continuously, no lock → grants alternate 0,1,0,1. Each rsp_valid arrives 2 cycles after its ready; never both ready in one cycle.
- r1_lock=1 with both valid, MAX_LOCK=16 → port 1 gets 16 consecutive grants, port 0 gets 1, then port 1 resumes.
- r1 writes 0x0000_0004 at addr 0x20; next cycle r0 reads 0x20 → r0_rdata=0x4.
- Assert reset_n=0 in the cycle after a write is accepted → no memory write: a later read of that word returns its old value, and no rsp_valid appears.
- With DM_ARB_RANGE_CHECK_EN: r0 write addr 0x0000_1000 → err=1, rdata=0, and a subsequent read of 0x0 is unchanged.
